mbr_block_responder: RTL and testbench
======================================

MBR_BLOCK_RESPONDER -- requirements
Module: mbr_block_responder

Interface
REQ-001 SHALL have parameter INIT_CYCLES, default 8, busy cycles after reset (emulated card init), legal range >=1.
REQ-002 SHALL have parameter BLOCK_LATENCY, default 16, busy cycles per block load, legal range >=1.
REQ-003 SHALL have parameter BYTE_LATENCY, default 2, busy cycles per byte fetch, legal range >=1.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 spi_r_block  input  1  block read request, held for the whole block transfer.
REQ-007 spi_r_byte  input  1  byte advance request, level-sampled in READY.
REQ-008 spi_block_addr  input  32  block number, latched at block accept.
REQ-009 spi_busy  output  1  responder busy; registered.
REQ-010 spi_err  output  1  request error; registered.
REQ-011 spi_data_out  output  8  current byte of the loaded block; registered.
REQ-012 part_lba  input  32  partition-1 start LBA placed in MBR image.
REQ-013 part_size  input  32  partition-1 sector count placed in MBR image.
REQ-014 bad_sig  input  1  test hook; corrupts MBR signature.
REQ-015 inject_err  input  1  test hook; next block request fails.
REQ-016 debug_leds  output  4  current state code.

Function
REQ-017 States SHALL be INIT=0, IDLE=1, LOAD=2, READY=3, BYTE_WAIT=4, ERROR=5, encoded on debug_leds.
REQ-018 INIT: busy=1 for exactly INIT_CYCLES cycles after reset release, then IDLE with busy=0.
REQ-019 IDLE: busy=0, err=0; spi_r_block=1 SHALL latch spi_block_addr, clear byte index to 0, go to ERROR if inject_err=1 else LOAD.
REQ-020 Busy SHALL assert the cycle after the accepting edge (requester sees busy=1 one cycle after its request).
REQ-021 LOAD: busy=1 for BLOCK_LATENCY cycles; on exit to READY, spi_data_out=byte[0], busy=0.
REQ-022 READY: busy=0; spi_r_byte=1 SHALL increment index and enter BYTE_WAIT.
REQ-023 BYTE_WAIT: busy=1 for BYTE_LATENCY cycles; on exit to READY, spi_data_out=byte[index], busy=0.
REQ-024 Index SHALL be 10 bits, saturating at 512; byte[i] for i>=512 SHALL be 0x00, no error.
REQ-025 spi_r_block=0 in LOAD, READY or BYTE_WAIT SHALL return to IDLE next cycle, busy=0, index=0; pending latency abandoned.
REQ-026 ERROR: err=1, busy=0, held until spi_r_block=0, then IDLE with err=0 next cycle.
REQ-027 Block 0 image: byte 0x1BE=0x80, 0x1C2=0x0C, 0x1C6..0x1C9=part_lba little-endian, 0x1CA..0x1CD=part_size little-endian, 0x1FE=0x55 (0x00 if bad_sig=1), 0x1FF=0xAA, all others 0x00.
REQ-028 Block N!=0 image: byte[i] = (N + i) mod 256, truncated to 8 bits.
REQ-029 part_lba, part_size, bad_sig SHALL be sampled when the byte is presented, not at block accept.
REQ-030 spi_r_byte outside READY SHALL be ignored.

Reset
REQ-031 Reset SHALL force INIT, busy=1, err=0, spi_data_out=0x00, index=0, latched addr=0, latency counter=INIT_CYCLES, asynchronously, including mid-transfer.

Verification
REQ-032 Reset release -> busy=1 for 8 cycles, then 0, debug_leds=1.
REQ-033 Paired with the team's MBR partition look-up FSM, part_lba=0x00002000 -> look-up success=1, start_reg=0x00002000 after 512 byte reads.
REQ-034 Same with bad_sig=1 -> byte 0x1FE reads 0x00, look-up err_signal=1.
REQ-035 Block 5 read, 3 byte advances -> data 0x05,0x06,0x07,0x08; 512th advance and beyond -> 0x00.
REQ-036 spi_r_block dropped on 5th LOAD cycle -> busy=0 next cycle, IDLE; re-request reloads and presents byte[0].
REQ-037 inject_err=1 with spi_r_block -> err=1 next cycle, busy=0; err clears one cycle after spi_r_block=0.

Source files
------------

// File: rtl/mbr_block_responder.sv
// Emulated SD-card block responder: serves a synthetic MBR in block 0 and a
// counting pattern in every other block, one byte per request, with busy timing.
module mbr_block_responder #(
  parameter int INIT_CYCLES   = 8,
  parameter int BLOCK_LATENCY = 16,
  parameter int BYTE_LATENCY  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_r_block,
  input  logic        spi_r_byte,
  input  logic [31:0] spi_block_addr,
  output logic        spi_busy,
  output logic        spi_err,
  output logic [7:0]  spi_data_out,
  input  logic [31:0] part_lba,
  input  logic [31:0] part_size,
  input  logic        bad_sig,
  input  logic        inject_err,
  output logic [3:0]  debug_leds
);

  localparam int MAX_A   = (INIT_CYCLES > BLOCK_LATENCY) ? INIT_CYCLES : BLOCK_LATENCY;
  localparam int MAX_LAT = (MAX_A > BYTE_LATENCY) ? MAX_A : BYTE_LATENCY;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_IDLE      = 3'd1,
    S_LOAD      = 3'd2,
    S_READY     = 3'd3,
    S_BYTE_WAIT = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [9:0]    idx, idx_n;
  logic [31:0]   addr, addr_n;
  logic          busy_n, err_n;
  logic [7:0]    data_n;
  logic [7:0]    byte_val;

  // Image content is computed live so partition inputs are taken at presentation time.
  always_comb begin
    byte_val = 8'h00;
    if (idx[9]) begin
      byte_val = 8'h00;
    end else if (addr == 32'd0) begin
      case (idx[8:0])
        9'h1BE:  byte_val = 8'h80;
        9'h1C2:  byte_val = 8'h0C;
        9'h1C6:  byte_val = part_lba[7:0];
        9'h1C7:  byte_val = part_lba[15:8];
        9'h1C8:  byte_val = part_lba[23:16];
        9'h1C9:  byte_val = part_lba[31:24];
        9'h1CA:  byte_val = part_size[7:0];
        9'h1CB:  byte_val = part_size[15:8];
        9'h1CC:  byte_val = part_size[23:16];
        9'h1CD:  byte_val = part_size[31:24];
        9'h1FE:  byte_val = bad_sig ? 8'h00 : 8'h55;
        9'h1FF:  byte_val = 8'hAA;
        default: byte_val = 8'h00;
      endcase
    end else begin
      byte_val = addr[7:0] + idx[7:0];
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    addr_n  = addr;
    busy_n  = spi_busy;
    err_n   = spi_err;
    data_n  = spi_data_out;
    case (state)
      S_INIT: begin
        if (cnt <= CW'(1)) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_IDLE: begin
        busy_n = 1'b0;
        err_n  = 1'b0;
        if (spi_r_block) begin
          addr_n = spi_block_addr;
          idx_n  = 10'd0;
          if (inject_err) begin
            state_n = S_ERROR;
            err_n   = 1'b1;
          end else begin
            state_n = S_LOAD;
            busy_n  = 1'b1;
            cnt_n   = CW'(BLOCK_LATENCY);
          end
        end
      end
      S_LOAD, S_BYTE_WAIT: begin
        // Releasing the block request abandons whatever latency is pending.
        if (!spi_r_block) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
          idx_n   = 10'd0;
        end else if (cnt <= CW'(1)) begin
          state_n = S_READY;
          busy_n  = 1'b0;
          data_n  = byte_val;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_READY: begin
        if (!spi_r_block) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
          idx_n   = 10'd0;
        end else if (spi_r_byte) begin
          state_n = S_BYTE_WAIT;
          busy_n  = 1'b1;
          cnt_n   = CW'(BYTE_LATENCY);
          idx_n   = (idx == 10'd512) ? idx : idx + 10'd1;
        end
      end
      S_ERROR: begin
        busy_n = 1'b0;
        err_n  = 1'b1;
        if (!spi_r_block) begin
          state_n = S_IDLE;
          err_n   = 1'b0;
        end
      end
      default: begin
        state_n = S_INIT;
        busy_n  = 1'b1;
        err_n   = 1'b0;
        cnt_n   = CW'(INIT_CYCLES);
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_INIT;
      cnt          <= CW'(INIT_CYCLES);
      idx          <= 10'd0;
      addr         <= 32'd0;
      spi_busy     <= 1'b1;
      spi_err      <= 1'b0;
      spi_data_out <= 8'h00;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      addr         <= addr_n;
      spi_busy     <= busy_n;
      spi_err      <= err_n;
      spi_data_out <= data_n;
    end
  end

  assign debug_leds = {1'b0, state};

endmodule

// File: tb/tb_mbr_block_responder.sv
// Self-checking bench for mbr_block_responder: scoreboard of expected bytes,
// one task per scenario.
module tb_mbr_block_responder;

  localparam int INIT_C = 8;
  localparam int BLK_C  = 16;
  localparam int BYTE_C = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_r_block = 1'b0;
  logic        spi_r_byte = 1'b0;
  logic [31:0] spi_block_addr = 32'd0;
  logic        spi_busy;
  logic        spi_err;
  logic [7:0]  spi_data_out;
  logic [31:0] part_lba = 32'd0;
  logic [31:0] part_size = 32'd0;
  logic        bad_sig = 1'b0;
  logic        inject_err = 1'b0;
  logic [3:0]  debug_leds;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  sb[$];

  always #5 clk = ~clk;

  mbr_block_responder #(
    .INIT_CYCLES(INIT_C), .BLOCK_LATENCY(BLK_C), .BYTE_LATENCY(BYTE_C)
  ) dut (
    .clk(clk), .reset(reset), .spi_r_block(spi_r_block), .spi_r_byte(spi_r_byte),
    .spi_block_addr(spi_block_addr), .spi_busy(spi_busy), .spi_err(spi_err),
    .spi_data_out(spi_data_out), .part_lba(part_lba), .part_size(part_size),
    .bad_sig(bad_sig), .inject_err(inject_err), .debug_leds(debug_leds)
  );

  function automatic logic [7:0] exp_byte(input logic [31:0] blk, input int i,
                                          input logic [31:0] lba, input logic [31:0] size,
                                          input logic bad);
    logic [7:0] r;
    r = 8'h00;
    if (i >= 512) r = 8'h00;
    else if (blk == 32'd0) begin
      if (i == 446) r = 8'h80;
      else if (i == 450) r = 8'h0C;
      else if (i >= 454 && i <= 457) r = 8'((lba >> (8 * (i - 454))) & 32'hFF);
      else if (i >= 458 && i <= 461) r = 8'((size >> (8 * (i - 458))) & 32'hFF);
      else if (i == 510) r = bad ? 8'h00 : 8'h55;
      else if (i == 511) r = 8'hAA;
    end else begin
      r = 8'((blk + 32'(i)) % 256);
    end
    return r;
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (spi_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic advance(output bit ok);
    spi_r_byte = 1'b1;
    @(posedge clk); #1;
    spi_r_byte = 1'b0;
    wait_ready(ok);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (spi_busy !== 1'b1 || spi_err !== 1'b0 || spi_data_out !== 8'h00 || debug_leds !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b err=%b data=%h leds=%h, required 1 0 00 0",
               spi_busy, spi_err, spi_data_out, debug_leds);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < INIT_C; i++) begin
      n_tests++;
      if (spi_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL init_busy cycle %0d: busy=%b, required 1", i, spi_busy);
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (spi_busy !== 1'b0 || debug_leds !== 4'd1) begin
      n_fail++;
      $display("FAIL init_done: busy=%b leds=%h, required 0 1", spi_busy, debug_leds);
    end
  endtask

  task automatic test_block5();
    int cyc;
    bit ok;
    logic [7:0] e;
    spi_block_addr = 32'd5;
    spi_r_block = 1'b1;
    sb.push_back(exp_byte(32'd5, 0, part_lba, part_size, bad_sig));
    @(posedge clk); #1;
    n_tests++;
    if (spi_busy !== 1'b1 || debug_leds !== 4'd2) begin
      n_fail++;
      $display("FAIL load_start: busy=%b leds=%h, required 1 2", spi_busy, debug_leds);
    end
    cyc = 0;
    while (spi_busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (cyc != BLK_C) begin
      n_fail++;
      $display("FAIL load_latency: busy cycles=%0d, required %0d", cyc, BLK_C);
    end
    e = sb.pop_front();
    n_tests++;
    if (spi_data_out !== e || debug_leds !== 4'd3) begin
      n_fail++;
      $display("FAIL blk5_byte0: data=%h leds=%h, required %h 3", spi_data_out, debug_leds, e);
    end
    sb.push_back(exp_byte(32'd5, 1, part_lba, part_size, bad_sig));
    spi_r_byte = 1'b1;
    @(posedge clk); #1;
    spi_r_byte = 1'b0;
    n_tests++;
    if (debug_leds !== 4'd4) begin
      n_fail++;
      $display("FAIL byte_wait_state: leds=%h, required 4", debug_leds);
    end
    cyc = 0;
    while (spi_busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (cyc != BYTE_C) begin
      n_fail++;
      $display("FAIL byte_latency: busy cycles=%0d, required %0d", cyc, BYTE_C);
    end
    e = sb.pop_front();
    n_tests++;
    if (spi_data_out !== e) begin
      n_fail++;
      $display("FAIL blk5_byte1: data=%h, required %h", spi_data_out, e);
    end
    for (int k = 2; k <= 514; k++) begin
      sb.push_back(exp_byte(32'd5, k, part_lba, part_size, bad_sig));
      advance(ok);
      e = sb.pop_front();
      n_tests++;
      if (!ok || spi_data_out !== e) begin
        n_fail++;
        $display("FAIL blk5_advance %0d: data=%h ready=%b, required %h", k, spi_data_out, ok, e);
      end
    end
    spi_r_block = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (debug_leds !== 4'd1 || spi_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL blk5_release: leds=%h busy=%b, required 1 0", debug_leds, spi_busy);
    end
  endtask

  task automatic test_abort();
    bit ok;
    logic [7:0] e;
    spi_block_addr = 32'h33;
    spi_r_block = 1'b1;
    spi_r_byte = 1'b1;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    spi_r_byte = 1'b0;
    @(posedge clk); #1;
    spi_r_block = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (spi_busy !== 1'b0 || debug_leds !== 4'd1) begin
      n_fail++;
      $display("FAIL abort_load: busy=%b leds=%h, required 0 1", spi_busy, debug_leds);
    end
    spi_r_block = 1'b1;
    spi_r_byte = 1'b1;
    sb.push_back(exp_byte(32'h33, 0, part_lba, part_size, bad_sig));
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    spi_r_byte = 1'b0;
    wait_ready(ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || spi_data_out !== e || debug_leds !== 4'd3) begin
      n_fail++;
      $display("FAIL reload_byte0: data=%h leds=%h ready=%b, required %h 3", spi_data_out, debug_leds, ok, e);
    end
    sb.push_back(exp_byte(32'h33, 1, part_lba, part_size, bad_sig));
    advance(ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || spi_data_out !== e) begin
      n_fail++;
      $display("FAIL reload_byte1: data=%h ready=%b, required %h", spi_data_out, ok, e);
    end
    spi_r_block = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mbr(input logic bad);
    bit ok;
    logic [7:0]  e;
    logic [31:0] start_reg;
    logic [7:0]  sig0, sig1;
    start_reg = 32'd0;
    sig0 = 8'h00;
    sig1 = 8'h00;
    bad_sig = bad;
    part_lba = 32'h0000_2000;
    part_size = 32'h1111_1111;
    spi_block_addr = 32'd0;
    spi_r_block = 1'b1;
    @(posedge clk); #1;
    part_size = 32'h0003_E800;
    sb.push_back(exp_byte(32'd0, 0, part_lba, part_size, bad_sig));
    wait_ready(ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || spi_data_out !== e) begin
      n_fail++;
      $display("FAIL mbr%0d_byte0: data=%h, required %h", bad, spi_data_out, e);
    end
    for (int k = 1; k < 512; k++) begin
      sb.push_back(exp_byte(32'd0, k, part_lba, part_size, bad_sig));
      advance(ok);
      e = sb.pop_front();
      n_tests++;
      if (!ok || spi_data_out !== e) begin
        n_fail++;
        $display("FAIL mbr%0d_byte %0d: data=%h ready=%b, required %h", bad, k, spi_data_out, ok, e);
      end
      if (k >= 454 && k <= 457) start_reg[8*(k-454) +: 8] = spi_data_out;
      if (k == 510) sig0 = spi_data_out;
      if (k == 511) sig1 = spi_data_out;
    end
    n_tests++;
    if (start_reg !== 32'h0000_2000) begin
      n_fail++;
      $display("FAIL mbr%0d_start_reg: got %h, required 00002000", bad, start_reg);
    end
    n_tests++;
    if ((sig0 === 8'h55 && sig1 === 8'hAA) !== !bad) begin
      n_fail++;
      $display("FAIL mbr%0d_signature: got %h%h, required valid=%b", bad, sig0, sig1, !bad);
    end
    spi_r_block = 1'b0;
    bad_sig = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_error();
    inject_err = 1'b1;
    spi_block_addr = 32'd7;
    spi_r_block = 1'b1;
    @(posedge clk); #1;
    inject_err = 1'b0;
    n_tests++;
    if (spi_err !== 1'b1 || spi_busy !== 1'b0 || debug_leds !== 4'd5) begin
      n_fail++;
      $display("FAIL err_assert: err=%b busy=%b leds=%h, required 1 0 5", spi_err, spi_busy, debug_leds);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (spi_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_hold: err=%b, required 1", spi_err);
    end
    spi_r_block = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (spi_err !== 1'b0 || debug_leds !== 4'd1) begin
      n_fail++;
      $display("FAIL err_clear: err=%b leds=%h, required 0 1", spi_err, debug_leds);
    end
  endtask

  task automatic test_reset_midtransfer();
    bit ok;
    spi_block_addr = 32'd9;
    spi_r_block = 1'b1;
    @(posedge clk); #1;
    wait_ready(ok);
    spi_r_byte = 1'b1;
    @(posedge clk); #1;
    spi_r_byte = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (spi_busy !== 1'b1 || spi_err !== 1'b0 || spi_data_out !== 8'h00 || debug_leds !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b err=%b data=%h leds=%h, required 1 0 00 0",
               spi_busy, spi_err, spi_data_out, debug_leds);
    end
    spi_r_block = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (INIT_C) @(posedge clk);
    #1;
    n_tests++;
    if (spi_busy !== 1'b0 || debug_leds !== 4'd1) begin
      n_fail++;
      $display("FAIL reinit_done: busy=%b leds=%h, required 0 1", spi_busy, debug_leds);
    end
  endtask

  initial begin
    test_reset();
    test_block5();
    test_abort();
    test_mbr(1'b0);
    test_mbr(1'b1);
    test_error();
    test_reset_midtransfer();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
